alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered ALU-control decoder for the pipelined RV32 core: the producing end of the ALU's `ALUControl` interface. It decodes the Decode-stage instruction into the 3-bit ALU operation code and the datapath controls for the Execute stage, then holds them in the ID/EX control register with stall, flush and valid handling. It also flags unsupported instructions and keeps a saturating count of them for debug.

## Interface
- No parameters; widths are fixed at RV32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `InstrD`  in  32  instruction in Decode.
- `ValidD`  in  1  `InstrD` is a real instruction, not a bubble.
- `StallE`  in  1  hold the ID/EX control register.
- `FlushE`  in  1  load a bubble into ID/EX.
- `ALUControlE`  out  3  operation code:
  - 000 add, 001 sub, 010 and, 011 or, 101 slt.
  - Other codes are never produced.
- `ALUSrcE`  out  1  B operand select: 1 = immediate, 0 = rs2.
- `RegWriteE`  out  1  writeback enable.
- `MemWriteE`  out  1  store enable.
- `ResultSrcE`  out  2  writeback select: 00 = ALU result, 01 = memory.
- `BranchE`  out  1  conditional branch; taken when the ALU `Zero` flag is 1.
- `ValidE`  out  1  Execute slot holds a real instruction.
- `IllegalE`  out  1  Execute slot holds an unsupported instruction.
- `IllegalCount`  out  8  saturating count of illegal instructions that have entered Execute.

## Operation
Decode is combinational from `InstrD` (opcode [6:0], funct3 [14:12], funct7 [31:25]). Every output of this block is registered.

Supported instructions (any control not listed below is 0):
- Opcode 0110011 (R-type), funct7 = 0000000:
  - funct3 000 → add.
  - funct3 111 → and.
  - funct3 110 → or.
  - funct3 010 → slt.
  - Sets RegWrite = 1.
- Opcode 0110011, funct7 = 0100000, funct3 000 → sub, RegWrite = 1.
- Any other R-type funct7/funct3 combination is illegal.
- Opcode 0010011 (I-type ALU), funct3 000/111/110/010 → add/and/or/slt.
  - Sets ALUSrc = 1, RegWrite = 1.
  - Other funct3 values are illegal.
- Opcode 0000011 (load), funct3 010 → add, ALUSrc = 1, RegWrite = 1, ResultSrc = 01.
- Opcode 0100011 (store), funct3 010 → add, ALUSrc = 1, MemWrite = 1.
- Opcode 1100011 (branch), funct3 000 → sub, Branch = 1.
- All other opcodes, and any funct3 not listed above, are illegal.

Illegal instructions:
- Loaded with every control at 0 and ALUControl = 000.
- `IllegalE` = 1 and `ValidE` = 1. The trap is taken downstream; this block only flags it.

ID/EX register update, in priority order:
1. `FlushE` = 1 → load a bubble: all outputs 0 except `IllegalCount`. Flush overrides a simultaneous stall.
2. `StallE` = 1 → hold all registers, including `IllegalCount`.
3. Otherwise:
   - `ValidD` = 1 → load the decoded controls.
   - `ValidD` = 0 → load a bubble. The decode result is ignored and `IllegalE` = 0 even if `InstrD` is garbage.

`IllegalCount`:
- Increments by 1 only when a valid illegal instruction is loaded under case 3.
- Saturates at 255 and does not wrap.
- Cleared only by reset.

## Timing
- Latency: one cycle. Controls for `InstrD` sampled at edge N appear on the outputs after edge N.
- No combinational path from any input to any output.
- Reset: while `rst_n` = 0, all outputs are 0 immediately (asynchronous), including `IllegalCount` = 0 and `ALUControlE` = 000.
- Reset deassertion: the first load happens on the first rising edge with `rst_n` = 1.
- Reset asserted mid-stall or mid-flush: reset wins; no pending state survives.
- Stall hold: outputs stay bit-identical across any number of consecutive stall cycles.
- Stall released: the instruction presented in the release cycle loads on the next edge.
- Counter boundary: an illegal load while `IllegalCount` = 255 leaves it at 255; `IllegalE` still asserts.

## Test plan
- Reset, then `InstrD` = 0x002081B3 (add x3,x1,x2) with `ValidD` = 1 → next edge: `ALUControlE` = 000, `RegWriteE` = 1, `ALUSrcE` = 0, `ValidE` = 1, `IllegalE` = 0.
- Back-to-back 0x402081B3 (sub), 0x00208063 (beq), 0x0000A283 (lw x5,0(x1)) → on consecutive cycles:
  - 001 with RegWrite = 1.
  - 001 with `BranchE` = 1, RegWrite = 0.
  - 000 with `ALUSrcE` = 1, `ResultSrcE` = 01.
- Load add, then `StallE` = 1 for 3 cycles while `InstrD` = sub → outputs remain the add controls; after release, sub appears one edge later.
- `StallE` = `FlushE` = 1 with a valid add → bubble: `ValidE` = 0, all controls 0, `IllegalCount` unchanged.
- 0xFFFFFFFF with `ValidD` = 1, repeated 260 cycles → `IllegalE` = 1 each cycle; `IllegalCount` reaches 255 and holds. The same word with `ValidD` = 0 → `IllegalE` = 0 and no count change.
- Assert `rst_n` = 0 asynchronously between edges while outputs are nonzero → all outputs read 0 before the next edge.

Source files
------------

// File: rtl/alu_decode_stage.sv
// Decode-stage ALU-control decoder feeding the ID/EX control register.
// Flags unsupported instructions and keeps a saturating debug count of them.
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] InstrD,
    input  logic        ValidD,
    input  logic        StallE,
    input  logic        FlushE,
    output logic [2:0]  ALUControlE,
    output logic        ALUSrcE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic [1:0]  ResultSrcE,
    output logic        BranchE,
    output logic        ValidE,
    output logic        IllegalE,
    output logic [7:0]  IllegalCount
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_t;

    typedef struct packed {
        alu_op_t    alu;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{alu: ALU_ADD, alu_src: 1'b0, reg_write: 1'b0,
                                    mem_write: 1'b0, result_src: 2'b00, branch: 1'b0};

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      ctrl_d;
    logic       legal_d;
    ctrl_t      ctrl_q;
    logic       valid_q;
    logic       illegal_q;
    logic [7:0] count_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];

    // funct3 -> ALU op shared by R-type and I-type arithmetic.
    function automatic logic arith_op(input logic [2:0] f3, output alu_op_t op);
        op = ALU_ADD;
        arith_op = 1'b1;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b010:  op = ALU_SLT;
            default: arith_op = 1'b0;
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        ctrl_d  = CTRL_NONE;
        legal_d = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000) begin
                    legal_d = arith_op(funct3, ctrl_d.alu);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal_d    = 1'b1;
                    ctrl_d.alu = ALU_SUB;
                end
                ctrl_d.reg_write = 1'b1;
            end
            OP_I: begin
                legal_d          = arith_op(funct3, ctrl_d.alu);
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            OP_LOAD: begin
                legal_d           = (funct3 == 3'b010);
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = 2'b01;
            end
            OP_STORE: begin
                legal_d          = (funct3 == 3'b010);
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                legal_d       = (funct3 == 3'b000);
                ctrl_d.alu    = ALU_SUB;
                ctrl_d.branch = 1'b1;
            end
            default: legal_d = 1'b0;
        endcase
        // Illegal words travel down the pipe with every control cleared.
        if (!legal_d) begin
            ctrl_d = CTRL_NONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_NONE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= 8'd0;
        end else if (FlushE) begin
            ctrl_q    <= CTRL_NONE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!StallE) begin
            if (ValidD) begin
                ctrl_q    <= ctrl_d;
                valid_q   <= 1'b1;
                illegal_q <= !legal_d;
                if (!legal_d && count_q != 8'hFF) begin
                    count_q <= count_q + 8'd1;
                end
            end else begin
                ctrl_q    <= CTRL_NONE;
                valid_q   <= 1'b0;
                illegal_q <= 1'b0;
            end
        end
    end

    assign ALUControlE  = ctrl_q.alu;
    assign ALUSrcE      = ctrl_q.alu_src;
    assign RegWriteE    = ctrl_q.reg_write;
    assign MemWriteE    = ctrl_q.mem_write;
    assign ResultSrcE   = ctrl_q.result_src;
    assign BranchE      = ctrl_q.branch;
    assign ValidE       = valid_q;
    assign IllegalE     = illegal_q;
    assign IllegalCount = count_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: a reference register model pushes the
// expected ID/EX contents into a queue that is popped after every clock edge.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [2:0] alu;
        logic       src;
        logic       regw;
        logic       memw;
        logic [1:0] res;
        logic       br;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        ctl_t       ctl;
        logic       valid;
        logic [7:0] cnt;
    } exp_t;

    // Expected decodes written out by hand for each test word.
    localparam ctl_t C_ADD   = '{3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_SUB   = '{3'b001, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_OR    = '{3'b011, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_SLT   = '{3'b101, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_ANDI  = '{3'b010, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_SLTI  = '{3'b101, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_LW    = '{3'b000, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
    localparam ctl_t C_SW    = '{3'b000, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_BEQ   = '{3'b001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    localparam ctl_t C_ILL   = '{3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_ANDI = 32'h0070F093;
    localparam logic [31:0] I_SLTI = 32'h0070A093;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BNE  = 32'h00209063;
    localparam logic [31:0] I_LB   = 32'h00008283;
    localparam logic [31:0] I_XAND = 32'h4020F1B3;
    localparam logic [31:0] I_ONES = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] InstrD = '0;
    logic        ValidD = 1'b0;
    logic        StallE = 1'b0;
    logic        FlushE = 1'b0;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic [1:0]  ResultSrcE;
    logic        BranchE;
    logic        ValidE;
    logic        IllegalE;
    logic [7:0]  IllegalCount;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t model   = '0;
    exp_t sb[$];

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD),
        .StallE(StallE), .FlushE(FlushE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ValidE(ValidE),
        .IllegalE(IllegalE), .IllegalCount(IllegalCount)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        exp_t o;
        o.ctl   = '{ALUControlE, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE, BranchE, IllegalE};
        o.valid = ValidE;
        o.cnt   = IllegalCount;
        return o;
    endfunction

    task automatic check(input string tag, input exp_t obs, input exp_t exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got ctl=%b valid=%b cnt=%0d, want ctl=%b valid=%b cnt=%0d",
                   tag, obs.ctl, obs.valid, obs.cnt, exp.ctl, exp.valid, exp.cnt);
        end
    endtask

    // Drive one cycle of inputs, advance the reference register model, push it,
    // then pop and compare once the edge has loaded the DUT.
    task automatic step(input string tag, input logic [31:0] instr, input logic valid,
                        input logic stall, input logic flush, input ctl_t ctl);
        exp_t e;
        @(negedge clk);
        InstrD = instr;
        ValidD = valid;
        StallE = stall;
        FlushE = flush;
        if (flush) begin
            model.ctl   = '0;
            model.valid = 1'b0;
        end else if (!stall) begin
            if (valid) begin
                model.ctl   = ctl;
                model.valid = 1'b1;
                if (ctl.illegal && model.cnt != 8'd255) model.cnt = model.cnt + 8'd1;
            end else begin
                model.ctl   = '0;
                model.valid = 1'b0;
            end
        end
        sb.push_back(model);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, observed(), ~observed());
        end else begin
            e = sb.pop_front();
            check(tag, observed(), e);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("reset", observed(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic decode and back-to-back issue
        step("add",  I_ADD, 1, 0, 0, C_ADD);
        step("sub",  I_SUB, 1, 0, 0, C_SUB);
        step("beq",  I_BEQ, 1, 0, 0, C_BEQ);
        step("lw",   I_LW,  1, 0, 0, C_LW);
        step("sw",   I_SW,  1, 0, 0, C_SW);
        step("or",   I_OR,  1, 0, 0, C_OR);
        step("slt",  I_SLT, 1, 0, 0, C_SLT);
        step("andi", I_ANDI, 1, 0, 0, C_ANDI);
        step("slti", I_SLTI, 1, 0, 0, C_SLTI);

        // Illegal encodings of otherwise supported opcodes
        step("ill_rtype",  I_XAND, 1, 0, 0, C_ILL);
        step("ill_bne",    I_BNE,  1, 0, 0, C_ILL);
        step("ill_lb",     I_LB,   1, 0, 0, C_ILL);
        step("bubble_inv", I_ONES, 0, 0, 0, C_ILL);

        // Stall holds, release loads the presented instruction
        step("stall_load", I_ADD, 1, 0, 0, C_ADD);
        for (int i = 0; i < 3; i++) step("stall_hold", I_SUB, 1, 1, 0, C_SUB);
        step("stall_rel",  I_SUB, 1, 0, 0, C_SUB);
        step("stall_ill",  I_ONES, 1, 1, 0, C_ILL);

        // Flush beats stall
        step("flush_stall", I_ADD, 1, 1, 1, C_ADD);
        step("post_flush",  I_LW,  1, 0, 0, C_LW);

        // Counter saturation
        for (int i = 0; i < 260; i++) step("sat", I_ONES, 1, 0, 0, C_ILL);
        step("sat_invalid", I_ONES, 0, 0, 0, C_ILL);
        step("sat_legal",   I_ADD,  1, 0, 0, C_ADD);

        // Asynchronous reset mid-stall, between edges
        step("pre_rst_stall", I_SUB, 1, 1, 0, C_SUB);
        @(negedge clk);
        StallE = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", observed(), '0);
        model = '0;
        sb.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        StallE = 1'b0;
        step("post_rst", I_BEQ, 1, 0, 0, C_BEQ);
        step("post_rst_ill", I_BNE, 1, 0, 0, C_ILL);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
